// File: rtl/scan_bridge_merge_core_pkg.sv
// Shared types and chain-layout arithmetic for the merge_core scan bridge.
// Field offsets are functions of the block parameters so every user agrees on the layout.
package merge_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SHIFT   = 2'b01,
        CAPTURE = 2'b10,
        UPDATE  = 2'b11
    } scan_state_t;

    typedef enum logic [1:0] {
        RUN_IDLE = 2'b00,
        RUN_BUSY = 2'b01,
        RUN_DONE = 2'b10
    } run_state_t;

    // Update word: rst_core, mode, wr_req, run_req, then the wide fields
    localparam int CTL_BITS  = 4;
    // Capture word: hold_valid, busy, done, then the wide fields
    localparam int FLAG_BITS = 3;

    function automatic int off_wr_addr();
        return CTL_BITS;
    endfunction

    function automatic int off_rd_addr(input int num_stgs);
        return CTL_BITS + num_stgs;
    endfunction

    function automatic int off_data_in(input int num_stgs, input int rd_w);
        return off_rd_addr(num_stgs) + rd_w;
    endfunction

    function automatic int off_run_cycles(input int num_stgs, input int rd_w, input int data_w);
        return off_data_in(num_stgs, rd_w) + data_w;
    endfunction

    function automatic int in_len(input int num_stgs, input int rd_w, input int data_w,
                                  input int run_w);
        return off_run_cycles(num_stgs, rd_w, data_w) + run_w;
    endfunction

    function automatic int off_row_idx(input int out_addr_w);
        return FLAG_BITS + out_addr_w;
    endfunction

    function automatic int off_value(input int out_addr_w, input int row_w);
        return off_row_idx(out_addr_w) + row_w;
    endfunction

    function automatic int out_len(input int out_addr_w, input int row_w, input int prec);
        return off_value(out_addr_w, row_w) + prec;
    endfunction

    function automatic int chain_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_bridge_merge_core_if.sv
// Core-side bus between the scan bridge (master) and one merge_core instance (slave).
interface scan_bridge_merge_core_if #(
    parameter int NUM_STGS                  = 10,
    parameter int DATA_WIDTH_INPUT          = 64,
    parameter int BITS_UNIT_SELECTION       = 3,
    parameter int BITS_OUTPUT_ADDR_PER_UNIT = 6,
    parameter int BITS_ROW_IDX              = 32,
    parameter int DATA_PRECISION            = 32
);
    logic                                                   rst_b_core;
    logic                                                   core_en;
    logic                                                   mode;
    logic                                                   wr_en_core_input;
    logic [NUM_STGS-1:0]                                    wr_addr_core_input;
    logic [DATA_WIDTH_INPUT-1:0]                            data_in_core;
    logic [BITS_UNIT_SELECTION+BITS_OUTPUT_ADDR_PER_UNIT-1:0] rd_addr_core_output;
    logic [BITS_OUTPUT_ADDR_PER_UNIT-1:0]                   wr_addr_core_output;
    logic                                                   core_out_valid;
    logic [BITS_ROW_IDX-1:0]                                core_out_row_idx;
    logic [DATA_PRECISION-1:0]                              core_out_value;

    modport master (
        output rst_b_core, core_en, mode, wr_en_core_input, wr_addr_core_input,
               data_in_core, rd_addr_core_output,
        input  wr_addr_core_output, core_out_valid, core_out_row_idx, core_out_value
    );

    modport slave (
        input  rst_b_core, core_en, mode, wr_en_core_input, wr_addr_core_input,
               data_in_core, rd_addr_core_output,
        output wr_addr_core_output, core_out_valid, core_out_row_idx, core_out_value
    );

endinterface

// File: rtl/scan_bridge_merge_core_run_ctl.sv
// Run counter for the merge core: core_en is asserted for exactly run_cycles enabled cycles,
// with busy/done reported back through the capture word.
module scan_run_ctl
    import merge_scan_pkg::*;
#(
    parameter int RUN_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RUN_CNT_W-1:0] run_cycles,
    input  logic                 en_run,
    output logic                 core_en,
    output logic                 busy,
    output logic                 done
);

    run_state_t           state_q;
    run_state_t           state_d;
    logic [RUN_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= RUN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over everything; a start request is ignored while a run is in flight
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = RUN_IDLE;
        end else begin
            case (state_q)
                RUN_BUSY: begin
                    if (en_run && (cnt == RUN_CNT_W'(1))) state_d = RUN_DONE;
                end
                default: begin
                    if (start) state_d = (run_cycles == '0) ? RUN_DONE : RUN_BUSY;
                end
            endcase
        end
    end

    always_comb begin
        busy    = (state_q == RUN_BUSY);
        done    = (state_q == RUN_DONE);
        core_en = (state_q == RUN_BUSY) && en_run;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start && (state_q != RUN_BUSY)) begin
            cnt <= run_cycles;
        end else if (core_en) begin
            cnt <= cnt - RUN_CNT_W'(1);
        end
    end

endmodule

// File: rtl/scan_bridge_merge_core.sv
// Scan bridge for one merge_core: serial shift/capture/update chain, shadow control
// register driving the core, one-shot write strobe, run control and a result hold latch.
module scan_bridge_merge_core
    import merge_scan_pkg::*;
#(
    parameter int NUM_STGS                  = 10,
    parameter int DATA_WIDTH_INPUT          = 64,
    parameter int BITS_UNIT_SELECTION       = 3,
    parameter int BITS_OUTPUT_ADDR_PER_UNIT = 6,
    parameter int BITS_ROW_IDX              = 32,
    parameter int DATA_PRECISION            = 32,
    parameter int RUN_CNT_W                 = 16
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [1:0]               scan_state_ctl_signal,
    input  logic                     scan_in,
    input  logic                     en_run,
    output logic                     scan_out,
    scan_bridge_merge_core_if.master core
);

    localparam int RD_W      = BITS_UNIT_SELECTION + BITS_OUTPUT_ADDR_PER_UNIT;
    localparam int IN_LEN    = in_len(NUM_STGS, RD_W, DATA_WIDTH_INPUT, RUN_CNT_W);
    localparam int OUT_LEN   = out_len(BITS_OUTPUT_ADDR_PER_UNIT, BITS_ROW_IDX, DATA_PRECISION);
    localparam int CHAIN_LEN = chain_len(IN_LEN, OUT_LEN);
    localparam int OFF_WR    = off_wr_addr();
    localparam int OFF_RD    = off_rd_addr(NUM_STGS);
    localparam int OFF_DATA  = off_data_in(NUM_STGS, RD_W);
    localparam int OFF_RUN   = off_run_cycles(NUM_STGS, RD_W, DATA_WIDTH_INPUT);

    scan_state_t                 state;
    scan_state_t                 state_q;
    logic                        upd_entry;
    logic [CHAIN_LEN-1:0]        sr;
    logic [CHAIN_LEN-1:0]        cap_chain;

    logic                        sh_rst_core;
    logic                        sh_mode;
    logic [NUM_STGS-1:0]         sh_wr_addr;
    logic [RD_W-1:0]             sh_rd_addr;
    logic [DATA_WIDTH_INPUT-1:0] sh_data_in;
    logic                        wr_en_q;

    logic                        hold_valid;
    logic [BITS_ROW_IDX-1:0]     hold_row_idx;
    logic [DATA_PRECISION-1:0]   hold_value;

    logic                        run_start;
    logic                        run_abort;
    logic                        core_en;
    logic                        busy;
    logic                        done;

    assign state     = scan_state_t'(scan_state_ctl_signal);
    // Only the first cycle of an update state acts; holding UPDATE is harmless
    assign upd_entry = (state == UPDATE) && (state_q != UPDATE);
    assign run_start = upd_entry && sr[3] && !sr[0];
    assign run_abort = upd_entry && sr[0];

    always_comb begin
        cap_chain                = '0;
        cap_chain[OUT_LEN-1:0]   = {hold_value, hold_row_idx, core.wr_addr_core_output,
                                    done, busy, hold_valid};
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= IDLE;
            sr       <= '0;
            scan_out <= 1'b0;
        end else begin
            state_q <= state;
            case (state)
                SHIFT: begin
                    sr       <= {scan_in, sr[CHAIN_LEN-1:1]};
                    scan_out <= sr[0];
                end
                CAPTURE: sr <= cap_chain;
                default: ;
            endcase
        end
    end

    // Shadow resets with the core held in reset
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sh_rst_core <= 1'b1;
            sh_mode     <= 1'b0;
            sh_wr_addr  <= '0;
            sh_rd_addr  <= '0;
            sh_data_in  <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            wr_en_q <= upd_entry && sr[2];
            if (upd_entry) begin
                sh_rst_core <= sr[0];
                sh_mode     <= sr[1];
                sh_wr_addr  <= sr[OFF_WR +: NUM_STGS];
                sh_rd_addr  <= sr[OFF_RD +: RD_W];
                sh_data_in  <= sr[OFF_DATA +: DATA_WIDTH_INPUT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hold_valid   <= 1'b0;
            hold_row_idx <= '0;
            hold_value   <= '0;
        end else if (core.core_out_valid) begin
            hold_valid   <= 1'b1;
            hold_row_idx <= core.core_out_row_idx;
            hold_value   <= core.core_out_value;
        end else if (upd_entry && sr[3]) begin
            hold_valid   <= 1'b0;
        end
    end

    scan_run_ctl #(
        .RUN_CNT_W (RUN_CNT_W)
    ) u_run_ctl (
        .clk        (clk),
        .rst_b      (rst_b),
        .start      (run_start),
        .abort      (run_abort),
        .run_cycles (sr[OFF_RUN +: RUN_CNT_W]),
        .en_run     (en_run),
        .core_en    (core_en),
        .busy       (busy),
        .done       (done)
    );

    assign core.rst_b_core          = ~sh_rst_core;
    assign core.mode                = sh_mode;
    assign core.wr_en_core_input    = wr_en_q;
    assign core.wr_addr_core_input  = sh_wr_addr;
    assign core.data_in_core        = sh_data_in;
    assign core.rd_addr_core_output = sh_rd_addr;
    assign core.core_en             = core_en;

endmodule

// File: doc/scan_bridge_merge_core.md
# scan_bridge_merge_core

Parametrised, single-clock scan bridge between the offchip scan pins and one `merge_core` instance. It replaces the fixed-width scan glue with a configurable shift / capture / update chain. It adds three behaviours:
- a programmable run counter that drives `core_en` for exactly N cycles;
- one-shot write strobes;
- a latch that holds the last valid core result until scan capture.

## Interface
Parameters:
- `NUM_STGS`, 10 — core input write-address width
- `DATA_WIDTH_INPUT`, 64 — core input data width
- `BITS_UNIT_SELECTION`, 3 — unit-select bits of the output read address
- `BITS_OUTPUT_ADDR_PER_UNIT`, 6 — per-unit output address bits
- `BITS_ROW_IDX`, 32 — result row index width
- `DATA_PRECISION`, 32 — result value width
- `RUN_CNT_W`, 16 — run counter width

Ports:
- `clk`  in  1  — single clock (scan and core domain)
- `rst_b`  in  1  — asynchronous, active-low reset
- `scan_state_ctl_signal`  in  2  — 00 idle, 01 shift, 10 capture, 11 update
- `scan_in`  in  1  — serial data in
- `en_run`  in  1  — run-counter enable; low pauses the run
- `scan_out`  out  1  — serial data out, registered
- `rst_b_core`  out  1  — core reset, active low
- `core_en`  out  1  — high while a run is counting
- `mode`  out  1  — core mode
- `wr_en_core_input`  out  1  — one-cycle write strobe
- `wr_addr_core_input`  out  `NUM_STGS`
- `data_in_core`  out  `DATA_WIDTH_INPUT`
- `rd_addr_core_output`  out  `BITS_UNIT_SELECTION+BITS_OUTPUT_ADDR_PER_UNIT`
- `wr_addr_core_output`  in  `BITS_OUTPUT_ADDR_PER_UNIT`
- `core_out_valid`  in  1
- `core_out_row_idx`  in  `BITS_ROW_IDX`
- `core_out_value`  in  `DATA_PRECISION`

## Operation
- **Update word**, LSB first:
  - `rst_core`[0], `mode`[1], `wr_req`[2], `run_req`[3]
  - `wr_addr` (`NUM_STGS`)
  - `rd_addr`
  - `data_in`
  - `run_cycles` (`RUN_CNT_W`)
  - Its length is `IN_LEN`.
- **Capture word**, LSB first:
  - `hold_valid`, `busy`, `done`
  - `wr_addr_core_output`
  - `hold_row_idx`, `hold_value`
  - Its length is `OUT_LEN`.
- **Shift register `sr`** is `CHAIN_LEN = max(IN_LEN, OUT_LEN)` bits.
  - Shift: `sr <= {scan_in, sr[CHAIN_LEN-1:1]}`; `scan_out <= sr[0]`.
  - Capture: `sr[OUT_LEN-1:0]` <= capture word; upper bits <= 0.
  - Update, first cycle only (entry detected against the previous-cycle state): shadow <= `sr[IN_LEN-1:0]`.
  - Holding the update state for several cycles has no further effect.
- **Shadow fields** drive outputs directly: `rst_b_core = ~rst_core`; `mode`, `wr_addr_core_input`, `data_in_core`, `rd_addr_core_output`.
- **`wr_en_core_input`**: one-cycle pulse the cycle after an update entry whose `wr_req` = 1.
- **Run control**:
  - Update entry with `run_req` = 1, `busy` = 0 and `rst_core` = 0 loads `cnt` = `run_cycles`, clears `done`, sets `busy`.
  - `run_cycles` = 0: `busy` stays 0 and `done` sets immediately.
  - While `busy` and `en_run`: `core_en` = 1 and `cnt` decrements. On the cycle `cnt` goes 1→0, `busy` and `core_en` clear and `done` sets.
  - `en_run` = 0: `core_en` = 0 and `cnt` holds.
  - `run_req` while `busy`: ignored; the other fields still update.
  - Abort: an update entry with `rst_core` = 1 clears `cnt`, `busy` and `core_en`; `done` stays 0.
- **Result hold**: each cycle `core_out_valid` = 1, `hold_row_idx` / `hold_value` load and `hold_valid` sets. It clears on update entry with `run_req` = 1.

## Timing
- **Reset values**:
  - `rst_b_core` = 0, because shadow `rst_core` resets to 1.
  - All other outputs = 0.
  - `sr`, `cnt`, `busy`, `done`, `hold_*` = 0.
- **Latencies**:
  - `scan_out` changes 1 cycle after a shift edge.
  - Shadow outputs are valid 1 cycle after the update-entry edge.
  - `wr_en_core_input` is high in exactly that same cycle.
- **Run length**: with `en_run` held high, `core_en` is high for exactly `run_cycles` consecutive cycles, starting the cycle after update entry.
- **Capture** samples the values present in the capture-state cycle. A `core_out_valid` in that same cycle is not visible; it appears in the next capture.
- **Reset mid-operation**: asynchronous `rst_b` returns everything to the reset values immediately, including a mid-shift chain. The chain must be reloaded.

## Structure
- **Package `merge_scan_pkg`**:
  - `scan_state_t` enum (`IDLE`, `SHIFT`, `CAPTURE`, `UPDATE`)
  - field-offset functions of the parameters
  - `IN_LEN`, `OUT_LEN`, `CHAIN_LEN` computation
- **Sub-module `scan_run_ctl`**: the run counter, the `busy`/`done` logic and `core_en` gating.
- **Top of this block**: the chain, the shadow register and the result hold.

## Test plan
- **Reset**: `rst_b` low → `rst_b_core` = 0, `core_en` = 0, `scan_out` = 0. Shift in 8 bits → `scan_out` replays them with 1-cycle lag after `CHAIN_LEN` shifts.
- **Write strobe**: update `wr_req` = 1, `wr_addr` = 0x155, `data_in` = 0xDEADBEEF_00000001, with update held 4 cycles → exactly one `wr_en_core_input` pulse, fields stable.
- **Run**: `run_req` = 1, `run_cycles` = 5, `en_run` = 1 → `core_en` high 5 cycles. Capture shows `busy` = 0, `done` = 1. With `run_cycles` = 0 → `done` = 1, `core_en` never high.
- **Pause**: `run_cycles` = 6 with `en_run` low for 3 cycles mid-run → 6 total `core_en` cycles across 9 cycles.
- **Abort**: `run_cycles` = 100, update with `rst_core` = 1 after 10 cycles → `core_en` low next cycle, `done` = 0, `rst_b_core` = 0.
- **Result hold**: `core_out_valid` pulse with `row_idx` = 42, `value` = 0x3F800000 → capture returns `hold_valid` = 1 with those values. A re-run request clears `hold_valid`.
